data_pack: RTL and testbench

DATA_PACK -- requirements
Module: data_pack

---
 rtl/data_pack_pkg.sv | 17 +
 rtl/data_pack_if.sv | 25 ++
 rtl/data_pack_datapath.sv | 83 ++++++++
 rtl/data_pack.sv | 85 ++++++++
 tb/tb_data_pack.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_pack_pkg.sv
// Shared constants and types for the 7-bit packet to 32-bit word packer.
// Both the pack side and the matching unpack side use these widths.
package data_pack_pkg;

  localparam int unsigned PKT_W  = 7;
  localparam int unsigned WORD_W = 32;
  // Largest accumulator need: 31 held bits plus one full packet.
  localparam int unsigned ACC_W  = WORD_W + PKT_W - 1;
  // The fill counter only ever holds 0..31 between cycles.
  localparam int unsigned FILL_W = 5;

  typedef enum logic {
    RUN,
    FLUSH_WAIT
  } state_e;

endpackage

// File: rtl/data_pack_if.sv
// Stream bus for data_pack.
//   in_data/in_valid/in_ready    : packet input, accepted on in_valid & in_ready
//   out_data/out_valid/out_ready : packed word output, consumed on out_valid & out_ready
// master = producer of packets / consumer of words; slave = the packer.
interface data_pack_if;
  import data_pack_pkg::*;

  logic [PKT_W-1:0]  in_data;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/data_pack_datapath.sv
// Datapath of the packer: 38-bit accumulator, fill counter and output register.
//   clk, rst   : clock, synchronous active-high reset
//   pkt_en     : append pkt at accumulator bit fill (shift-in), loading a word on overflow
//   flush_en   : load the zero-padded partial word and clear the accumulator
//   pkt        : packet to append
//   out_ready  : downstream consumes the output register this cycle
//   out_data   : output register contents
//   out_valid  : output register holds a word
//   out_free   : output register can take a new word this cycle
//   fill       : number of packed bits currently held
module data_pack_datapath
  import data_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_en,
  input  logic              flush_en,
  input  logic [PKT_W-1:0]  pkt,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_free,
  output logic [FILL_W-1:0] fill
);

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [ACC_W-1:0]  placed;
  logic [FILL_W-1:0] fill_next;
  logic              word_full;

  always_comb begin
    // Bits above fill are always zero, so OR-ing the packet in is enough.
    placed = acc_q | (ACC_W'(pkt) << fill_q);
    // The carry out of the 6-bit sum flags a full word; the low 5 bits are
    // already sum-32 in that case, so no separate subtract is needed.
    {word_full, fill_next} = {1'b0, fill_q} + (FILL_W + 1)'(PKT_W);

    acc_d       = acc_q;
    fill_d      = fill_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q & ~out_ready;

    if (flush_en) begin
      out_data_d  = acc_q[WORD_W-1:0];
      out_valid_d = 1'b1;
      acc_d       = '0;
      fill_d      = '0;
    end else if (pkt_en) begin
      fill_d = fill_next;
      if (word_full) begin
        out_data_d  = placed[WORD_W-1:0];
        out_valid_d = 1'b1;
        acc_d       = ACC_W'(placed[ACC_W-1:WORD_W]);
      end else begin
        acc_d = placed;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      fill_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_free  = ~out_valid_q | out_ready;
  assign fill      = fill_q;

endmodule

// File: rtl/data_pack.sv
// Packs a contiguous LSB-first stream of 7-bit packets into 32-bit words.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : data_pack_if.slave (packet input and word output handshakes)
//   flush      : single-cycle request to emit the partial word, zero-padded
//   fill       : packed bits currently held (0..31)
//   flush_done : one-cycle pulse when a flush completes
module data_pack
  import data_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  data_pack_if.slave        bus,
  input  logic              flush,
  output logic [FILL_W-1:0] fill,
  output logic              flush_done
);

  state_e state_q, state_d;
  logic   flush_done_q, flush_done_d;
  logic   pkt_en, flush_en, out_free, in_ready;
  logic [FILL_W-1:0] fill_w;

  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    pkt_en       = 1'b0;
    flush_en     = 1'b0;
    in_ready     = 1'b0;

    case (state_q)
      RUN: begin
        in_ready = out_free & ~flush;
        if (flush) begin
          if (fill_w == '0) begin
            flush_done_d = 1'b1;
          end else if (out_free) begin
            flush_en     = 1'b1;
            flush_done_d = 1'b1;
          end else begin
            state_d = FLUSH_WAIT;
          end
        end else begin
          pkt_en = bus.in_valid & in_ready;
        end
      end
      FLUSH_WAIT: begin
        // Further flush requests are ignored here; one padded word is owed.
        if (out_free) begin
          flush_en     = 1'b1;
          flush_done_d = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= flush_done_d;
    end
  end

  data_pack_datapath u_datapath (
    .clk       (clk),
    .rst       (rst),
    .pkt_en    (pkt_en),
    .flush_en  (flush_en),
    .pkt       (bus.in_data),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .out_free  (out_free),
    .fill      (fill_w)
  );

  assign bus.in_ready = in_ready;
  assign fill         = fill_w;
  assign flush_done   = flush_done_q;

endmodule

// File: tb/tb_data_pack.sv
// Directed self-checking bench for data_pack.
module tb_data_pack;
  import data_pack_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [FILL_W-1:0] fill;
  logic              flush_done;

  data_pack_if bus ();

  data_pack dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flush      (flush),
    .fill       (fill),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] words[$];
  logic [6:0]  sent[32];

  // Words are recorded on the falling edge ahead of the consuming rising edge.
  always @(negedge clk)
    if (!rst && bus.out_valid && bus.out_ready) words.push_back(bus.out_data);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    words.delete();
  endtask

  task automatic send(input logic [6:0] p);
    int unsigned n = 0;
    bus.in_data  = p;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=%0d expected<50", n);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    #1;
    chk("in_ready_in_flush", 32'(bus.in_ready), 32'h0);
    tick();
    flush = 1'b0;
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    flush         = 1'b0;
    rst           = 1'b1;

    // Reset state
    do_reset();
    chk("rst_fill",       32'(fill),          32'h0);
    chk("rst_out_valid",  32'(bus.out_valid), 32'h0);
    chk("rst_out_data",   bus.out_data,       32'h0);
    chk("rst_flush_done", 32'(flush_done),    32'h0);
    chk("rst_in_ready",   32'(bus.in_ready),  32'h1);

    // 0x01 then four 0x00
    send(7'h01);
    for (int i = 0; i < 4; i++) send(7'h00);
    chk("s1_out_valid", 32'(bus.out_valid), 32'h1);
    chk("s1_out_data",  bus.out_data,       32'h0000_0001);
    chk("s1_fill",      32'(fill),          32'd3);
    tick();
    chk("s1_words",     32'(words.size()),  32'd1);
    chk("s1_word0",     words[0],           32'h0000_0001);
    chk("s1_valid_clr", 32'(bus.out_valid), 32'h0);

    // five 0x7F, then zeros through fill=31 and past it
    do_reset();
    for (int i = 0; i < 5; i++) send(7'h7F);
    chk("s2_word_ones", bus.out_data, 32'hFFFF_FFFF);
    chk("s2_fill3",     32'(fill),    32'd3);
    for (int i = 0; i < 4; i++) send(7'h00);
    chk("s2_fill31",    32'(fill),          32'd31);
    chk("s2_no_word",   32'(bus.out_valid), 32'h0);
    chk("s2_words1",    32'(words.size()),  32'd1);
    send(7'h00);
    chk("s2_word7",     bus.out_data,       32'h0000_0007);
    chk("s2_valid",     32'(bus.out_valid), 32'h1);
    chk("s2_fill6",     32'(fill),          32'd6);

    // 0x55, 0x2A then flush; then flush with nothing held
    do_reset();
    send(7'h55);
    send(7'h2A);
    chk("s3_fill14", 32'(fill), 32'd14);
    do_flush();
    chk("s3_word",       bus.out_data,       32'h0000_1555);
    chk("s3_valid",      32'(bus.out_valid), 32'h1);
    chk("s3_fill0",      32'(fill),          32'h0);
    chk("s3_done",       32'(flush_done),    32'h1);
    tick();
    chk("s3_done_pulse", 32'(flush_done),    32'h0);
    do_flush();
    chk("s3_done_empty", 32'(flush_done),    32'h1);
    chk("s3_no_word",    32'(bus.out_valid), 32'h0);
    tick();
    chk("s3_words",      32'(words.size()),  32'd1);

    // Backpressure: word pending, next packet stalls, then both drain in order
    do_reset();
    bus.out_ready = 1'b0;
    send(7'h01);
    for (int i = 0; i < 4; i++) send(7'h00);
    chk("s4_word0", bus.out_data, 32'h0000_0001);
    bus.in_data  = 7'h7F;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s4_stall_ready", 32'(bus.in_ready), 32'h0);
      chk("s4_hold_data",   bus.out_data,      32'h0000_0001);
    end
    chk("s4_fill_held", 32'(fill), 32'd3);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) send(7'h7F);
    chk("s4_word1", bus.out_data, 32'hFFFF_FFF8);
    chk("s4_fill6", 32'(fill),    32'd6);
    tick();
    chk("s4_words", 32'(words.size()), 32'd2);
    chk("s4_ord0",  words[0], 32'h0000_0001);
    chk("s4_ord1",  words[1], 32'hFFFF_FFF8);

    // Flush while output blocked -> waits, then padded word follows
    do_reset();
    bus.out_ready = 1'b0;
    send(7'h01);
    for (int i = 0; i < 3; i++) send(7'h00);
    send(7'h7F);
    chk("s5_word0", bus.out_data, 32'hF000_0001);
    chk("s5_fill3", 32'(fill),    32'd3);
    do_flush();
    chk("s5_wait_ready", 32'(bus.in_ready), 32'h0);
    chk("s5_wait_done",  32'(flush_done),   32'h0);
    do_flush();
    bus.in_data  = 7'h7F;
    bus.in_valid = 1'b1;
    tick();
    chk("s5_no_accept", 32'(fill),   32'd3);
    chk("s5_hold",      bus.out_data, 32'hF000_0001);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("s5_valid",     32'(bus.out_valid), 32'h1);
    chk("s5_pad_word",  bus.out_data,       32'h0000_0007);
    chk("s5_done",      32'(flush_done),    32'h1);
    chk("s5_fill0",     32'(fill),          32'h0);
    chk("s5_run_ready", 32'(bus.in_ready),  32'h1);
    tick();
    chk("s5_done_clr",  32'(flush_done),    32'h0);
    chk("s5_words",     32'(words.size()),  32'd2);
    chk("s5_ord0",      words[0], 32'hF000_0001);
    chk("s5_ord1",      words[1], 32'h0000_0007);

    // Loopback: 32 random packets -> 7 words -> unpacked back to packets
    do_reset();
    for (int i = 0; i < 32; i++) begin
      sent[i] = 7'($urandom_range(0, 127));
      send(sent[i]);
    end
    tick();
    tick();
    chk("lb_words", 32'(words.size()), 32'd7);
    chk("lb_fill",  32'(fill),         32'h0);
    if (words.size() == 7) begin
      for (int i = 0; i < 32; i++) begin
        logic [6:0] got;
        for (int b = 0; b < 7; b++) begin
          int unsigned pos;
          pos    = 32'(7 * i + b);
          got[b] = words[pos / 32][pos % 32];
        end
        chk($sformatf("lb_pkt%0d", i), 32'(got), 32'(sent[i]));
      end
    end

    // Reset mid-word discards partial data
    send(7'h3C);
    send(7'h11);
    chk("rw_fill14", 32'(fill), 32'd14);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_fill0",  32'(fill),          32'h0);
    chk("rw_valid",  32'(bus.out_valid), 32'h0);
    do_flush();
    chk("rw_done",   32'(flush_done),    32'h1);
    chk("rw_noword", 32'(bus.out_valid), 32'h0);
    tick();
    chk("rw_words",  32'(words.size()),  32'd7);

    // Reset in FLUSH_WAIT drops both the pending and the owed word
    words.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(7'h7F);
    do_flush();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rf_valid", 32'(bus.out_valid), 32'h0);
    chk("rf_ready", 32'(bus.in_ready),  32'h1);
    chk("rf_fill",  32'(fill),          32'h0);
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rf_words", 32'(words.size()),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
